// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI-slave memory back end.
// Holds the 2-bit frame opcodes and the cmd_err cause codes used by
// spi_ram_ctrl and by anything that decodes its error output.
package spi_ram_pkg;

    // Frame opcodes, carried in the two MSBs of every received frame
    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    // Error causes reported on err_code while cmd_err is high
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NOT_ARMED = 2'b01;
    localparam logic [1:0] ERR_OVERRUN   = 2'b10;

endpackage

// File: rtl/spi_ram_mem.sv
// Simple dual-port synchronous word RAM (DATA_WIDTH x 2**ADDR_WIDTH).
// Ports:
//   clk, rst        clock / async active-high reset (output register only)
//   we, waddr, wdata   write port
//   re, raddr       read port; rdata register loads when re=1, holds otherwise
//   rdata           registered read word
// The array itself is not reset; only the output register clears so the
// read word seen by the SPI engine is 0 out of reset.
module spi_ram_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI-slave memory back end: decodes opcode-prefixed frames from the SPI
// shift engine into pointer loads, memory writes and memory reads, and
// returns read words through a valid/ready handshake.
// Ports:
//   clk, rst          clock / async active-high reset
//   rx_valid, rx_data received frame {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   tx_ready          SPI engine takes tx_data this cycle
//   tx_valid, tx_data read word offered to the SPI engine, held until taken
//   cmd_err, err_code one-cycle error pulse and its cause (00 when idle)
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  cmd_err,
    output logic [1:0]            err_code
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] payload;

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic                  rd_armed_d, rd_armed_q;
    logic                  tx_valid_d, tx_valid_q;
    logic                  cmd_err_d, cmd_err_q;
    logic [1:0]            err_code_d, err_code_q;
    logic                  mem_we;
    logic                  mem_re;

    assign opcode  = rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = rx_data[DATA_WIDTH-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_armed_d = rd_armed_q;
        // A pending word is retired when the engine takes it; a valid
        // RDATA below re-asserts it on the same edge for bubble-free bursts.
        tx_valid_d = tx_valid_q & ~tx_ready;
        cmd_err_d  = 1'b0;
        err_code_d = ERR_NONE;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (rx_valid) begin
            case (opcode)
                OP_WADDR: begin
                    wr_ptr_d = payload[ADDR_WIDTH-1:0];
                end
                OP_WDATA: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
                OP_RADDR: begin
                    rd_ptr_d   = payload[ADDR_WIDTH-1:0];
                    rd_armed_d = 1'b1;
                end
                default: begin
                    if (!rd_armed_q) begin
                        cmd_err_d  = 1'b1;
                        err_code_d = ERR_NOT_ARMED;
                    end else if (tx_valid_q && !tx_ready) begin
                        // Previous word still pending: drop this read.
                        cmd_err_d  = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end else begin
                        mem_re     = 1'b1;
                        tx_valid_d = 1'b1;
                        if (AUTO_INC != 0) begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_armed_q <= 1'b0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_armed_q <= rd_armed_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
            err_code_q <= err_code_d;
        end
    end

    // The RAM output register doubles as tx_data: it loads only on an
    // accepted read and holds otherwise, so a pending word stays stable.
    spi_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (payload),
        .re    (mem_re),
        .raddr (rd_ptr_q),
        .rdata (tx_data)
    );

    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;
    assign err_code = err_code_q;

endmodule
